// File: rtl/bcp_clause_eval.sv
// bcp_clause_eval -- Boolean-constraint-propagation clause evaluator.
//
// Clause indices are queued, then evaluated one at a time: the clause word is
// read from the clause database, the state of each valid literal's variable is
// read from var-state memory, and the clause is classified as satisfied,
// conflicting (every literal false), unit (exactly one unassigned literal, which
// is pushed to the implication FIFO) or unresolved (two or more unassigned).
//
// Ports
//   clock, reset      : clock and asynchronous active-high reset
//   reset_bcp         : synchronous clear of queue, FSM, conflict, overflow
//   bcp_en/_clause_idx: clause index enqueue strobe and value
//   bcp_busy          : work pending or in progress (combinational)
//   conflict          : sticky, some clause had every literal false
//   q_overflow        : sticky, an index was dropped on a full queue
//   cdb_read/addr/data: clause-database read (data one cycle after read)
//   vs_read/var/val/unassign : var-state read (data one cycle after read)
//   imply_push/var/val/type, imply_full : implication FIFO write port

`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 6
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

module bcp_clause_eval #(
  parameter int LITS   = 3,
  parameter int QDEPTH = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   reset_bcp,
  input  logic                                   bcp_en,
  input  logic [`MAX_CLAUSES_BITS-1:0]           bcp_clause_idx,
  output logic                                   bcp_busy,
  output logic                                   conflict,
  output logic                                   q_overflow,
  output logic                                   cdb_read,
  output logic [`MAX_CLAUSES_BITS-1:0]           cdb_addr,
  input  logic [LITS*(`MAX_VARS_BITS+2)-1:0]     cdb_data,
  output logic                                   vs_read,
  output logic [`MAX_VARS_BITS-1:0]              vs_var,
  input  logic                                   vs_val,
  input  logic                                   vs_unassign,
  output logic                                   imply_push,
  output logic [`MAX_VARS_BITS-1:0]              imply_var,
  output logic                                   imply_val,
  output logic                                   imply_type,
  input  logic                                   imply_full
);

  localparam int VB  = `MAX_VARS_BITS;
  localparam int CB  = `MAX_CLAUSES_BITS;
  localparam int SLW = VB + 2;
  localparam int QW  = $clog2(QDEPTH);
  localparam int SW  = $clog2(LITS + 1);
  localparam logic [QW:0] CNT_FULL = (QW+1)'(QDEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LREAD = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_PUSH  = 3'd4;

  // Slot k of a clause word is {valid, neg, var} at bits [k*SLW +: SLW].
  function automatic logic [VB-1:0] slot_var(input logic [LITS*SLW-1:0] lits,
                                             input logic [SW-1:0] idx);
    slot_var = '0;
    for (int k = 0; k < LITS; k++)
      if (idx == SW'(k)) slot_var = lits[k*SLW +: VB];
  endfunction

  function automatic logic slot_neg(input logic [LITS*SLW-1:0] lits,
                                    input logic [SW-1:0] idx);
    slot_neg = 1'b0;
    for (int k = 0; k < LITS; k++)
      if (idx == SW'(k)) slot_neg = lits[k*SLW + VB];
  endfunction

  logic [2:0]          r_state;
  logic [CB-1:0]       r_mem [QDEPTH];
  logic [QW-1:0]       r_wp, r_rp;
  logic [QW:0]         r_cnt;
  logic                r_conflict, r_ovf;
  logic [LITS*SLW-1:0] r_lits;
  logic [SW-1:0]       r_slot, r_pend_slot;
  logic                r_pend, r_any_true;
  logic [1:0]          r_n_un;
  logic [VB-1:0]       r_unit_var;
  logic                r_unit_neg;

  logic          w_pop, w_push_req, w_push, w_drop, w_set_conf, w_any_valid;
  logic          w_nxt_found, w_pend_neg, w_lit_true, w_lit_un;
  logic [SW-1:0] w_nxt_idx;

  // Pops only happen from IDLE, so a full queue can still accept an index in
  // the same cycle its head is popped.
  assign w_pop      = (r_state == S_IDLE) && (r_cnt != '0) && !r_conflict && !reset_bcp;
  assign w_set_conf = (r_state == S_EVAL) && !r_any_true && (r_n_un == 2'd0) && !reset_bcp;
  assign w_push_req = bcp_en && !r_conflict && !w_set_conf && !reset_bcp;
  assign w_push     = w_push_req && ((r_cnt != CNT_FULL) || w_pop);
  assign w_drop     = w_push_req && (r_cnt == CNT_FULL) && !w_pop;

  always_comb begin
    w_any_valid = 1'b0;
    for (int k = 0; k < LITS; k++) w_any_valid = w_any_valid | cdb_data[k*SLW + SLW - 1];
  end

  // Lowest valid slot at or above r_slot; invalid slots cost no cycle.
  always_comb begin
    w_nxt_found = 1'b0;
    w_nxt_idx   = '0;
    for (int k = LITS - 1; k >= 0; k--) begin
      if (r_lits[k*SLW + SLW - 1] && (SW'(k) >= r_slot)) begin
        w_nxt_found = 1'b1;
        w_nxt_idx   = SW'(k);
      end
    end
  end

  assign w_pend_neg = slot_neg(r_lits, r_pend_slot);
  assign w_lit_true = r_pend && !vs_unassign && (vs_val != w_pend_neg);
  assign w_lit_un   = r_pend && vs_unassign;

  assign bcp_busy   = bcp_en || (r_cnt != '0) || (r_state != S_IDLE);
  assign conflict   = r_conflict;
  assign q_overflow = r_ovf;
  assign cdb_read   = w_pop;
  assign cdb_addr   = w_pop ? r_mem[r_rp] : '0;
  assign vs_read    = (r_state == S_LREAD) && w_nxt_found && !reset_bcp;
  assign vs_var     = vs_read ? slot_var(r_lits, w_nxt_idx) : '0;
  assign imply_push = (r_state == S_PUSH) && !imply_full && !reset_bcp;
  assign imply_var  = imply_push ? r_unit_var : '0;
  assign imply_val  = imply_push && !r_unit_neg;
  assign imply_type = imply_push;

  // Queue storage
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wp] <= bcp_clause_idx;
  end

  // Queue control; a new conflict flushes everything still queued
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (reset_bcp || w_set_conf) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Sticky flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_conflict <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (reset_bcp) begin
      r_conflict <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_set_conf) r_conflict <= 1'b1;
      if (w_drop)     r_ovf      <= 1'b1;
    end
  end

  // Evaluation FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lits      <= '0;
      r_slot      <= '0;
      r_pend      <= 1'b0;
      r_pend_slot <= '0;
      r_any_true  <= 1'b0;
      r_n_un      <= 2'd0;
      r_unit_var  <= '0;
      r_unit_neg  <= 1'b0;
    end else if (reset_bcp) begin
      r_state <= S_IDLE;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_pop) r_state <= S_FETCH;
        S_FETCH: begin
          r_lits     <= cdb_data;
          r_slot     <= '0;
          r_pend     <= 1'b0;
          r_any_true <= 1'b0;
          r_n_un     <= 2'd0;
          r_state    <= w_any_valid ? S_LREAD : S_EVAL;
        end
        S_LREAD: begin
          // Capture the previous read's response while issuing the next read.
          if (w_lit_true) r_any_true <= 1'b1;
          if (w_lit_un) begin
            if (r_n_un != 2'd2) r_n_un <= r_n_un + 2'd1;
            r_unit_var <= slot_var(r_lits, r_pend_slot);
            r_unit_neg <= w_pend_neg;
          end
          r_pend      <= w_nxt_found;
          r_pend_slot <= w_nxt_idx;
          r_slot      <= w_nxt_idx + 1'b1;
          if (!w_nxt_found) r_state <= S_EVAL;
        end
        S_EVAL:  r_state <= (!r_any_true && r_n_un == 2'd1) ? S_PUSH : S_IDLE;
        S_PUSH:  if (!imply_full) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcp_clause_eval.sv
// Testbench for bcp_clause_eval: directed clauses against small clause-database
// and var-state memory models; implications are checked through a scoreboard.

`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 6
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

module tb_bcp_clause_eval;
  localparam int VB   = `MAX_VARS_BITS;
  localparam int CB   = `MAX_CLAUSES_BITS;
  localparam int LITS = 3;
  localparam int SLW  = VB + 2;

  logic clock = 1'b0;
  logic reset, reset_bcp, bcp_en, imply_full;
  logic [CB-1:0] bcp_clause_idx;
  logic bcp_busy, conflict, q_overflow, cdb_read, vs_read;
  logic [CB-1:0] cdb_addr;
  logic [LITS*SLW-1:0] cdb_data = '0;
  logic [VB-1:0] vs_var, imply_var;
  logic vs_val = 1'b0, vs_unassign = 1'b0;
  logic imply_push, imply_val, imply_type;

  bcp_clause_eval #(.LITS(LITS), .QDEPTH(4)) dut (
    .clock(clock), .reset(reset), .reset_bcp(reset_bcp), .bcp_en(bcp_en),
    .bcp_clause_idx(bcp_clause_idx), .bcp_busy(bcp_busy), .conflict(conflict),
    .q_overflow(q_overflow), .cdb_read(cdb_read), .cdb_addr(cdb_addr),
    .cdb_data(cdb_data), .vs_read(vs_read), .vs_var(vs_var), .vs_val(vs_val),
    .vs_unassign(vs_unassign), .imply_push(imply_push), .imply_var(imply_var),
    .imply_val(imply_val), .imply_type(imply_type), .imply_full(imply_full));

  always #5 clock = ~clock;

  logic [LITS*SLW-1:0] cdb_mem [0:(1<<CB)-1];
  logic vs_val_m [0:(1<<VB)-1];
  logic vs_un_m  [0:(1<<VB)-1];

  // Memory models: read data appears one cycle after the request
  always @(posedge clock) begin
    if (cdb_read) cdb_data <= cdb_mem[cdb_addr];
    if (vs_read) begin
      vs_val      <= vs_val_m[vs_var];
      vs_unassign <= vs_un_m[vs_var];
    end
  end

  int total = 0, bad = 0, n_cdb = 0, n_push = 0;
  int c0, p0;
  logic [VB+1:0] exp_q [$];
  logic [VB+1:0] exp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: pops the expected implication whenever the DUT pushes one
  always @(negedge clock) begin
    if (cdb_read) n_cdb++;
    if (imply_push) begin
      n_push++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_push: got var=%0d val=%0d type=%0d want none",
                 imply_var, imply_val, imply_type);
      end else begin
        exp_e = exp_q.pop_front();
        chk("imply", 32'({imply_var, imply_val, imply_type}), 32'(exp_e));
      end
    end
  end

  function automatic logic [SLW-1:0] slot(input logic n, input logic [VB-1:0] v);
    return {1'b1, n, v};
  endfunction

  task automatic enq(input logic [CB-1:0] idx);
    bcp_en = 1'b1;
    bcp_clause_idx = idx;
    @(posedge clock); #1;
    bcp_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bcp_busy && n < 200);
    chk({"idle_", name}, 32'(bcp_busy), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic pulse_reset_bcp();
    reset_bcp = 1'b1;
    @(posedge clock); #1;
    reset_bcp = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bcp_busy), 0);
    chk({tag, "_conf"}, 32'(conflict), 0);
    chk({tag, "_ovf"}, 32'(q_overflow), 0);
    chk({tag, "_cdb"}, 32'({cdb_read, cdb_addr}), 0);
    chk({tag, "_vs"}, 32'({vs_read, vs_var}), 0);
    chk({tag, "_imp"}, 32'({imply_push, imply_var, imply_val, imply_type}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << CB); i++) cdb_mem[i] = '0;
    for (int i = 0; i < (1 << VB); i++) begin
      vs_val_m[i] = 1'b0;
      vs_un_m[i]  = 1'b0;
    end
    // Unit clause: var3 positive, unassigned
    cdb_mem[5]  = {{SLW{1'b0}}, {SLW{1'b0}}, slot(1'b0, 6'd3)};
    vs_un_m[3]  = 1'b1;
    // Unit in slot 2: var13 negated unassigned, var14 positive but 0 (false)
    cdb_mem[11] = {slot(1'b1, 6'd13), slot(1'b0, 6'd14), {SLW{1'b0}}};
    vs_un_m[13] = 1'b1;
    // Satisfied: var4 negated with value 0 (true), var5 unassigned
    cdb_mem[7]  = {{SLW{1'b0}}, slot(1'b0, 6'd5), slot(1'b1, 6'd4)};
    vs_un_m[5]  = 1'b1;
    // Two unassigned literals
    cdb_mem[8]  = {{SLW{1'b0}}, slot(1'b1, 6'd11), slot(1'b0, 6'd10)};
    vs_un_m[10] = 1'b1;
    vs_un_m[11] = 1'b1;
    for (int i = 30; i < 36; i++) cdb_mem[i] = cdb_mem[8];
    // Conflict: v1=0 positive, v2=1 negated
    cdb_mem[2]  = {{SLW{1'b0}}, slot(1'b1, 6'd2), slot(1'b0, 6'd1)};
    vs_val_m[2] = 1'b1;
    for (int i = 20; i < 23; i++) cdb_mem[i] = cdb_mem[5];
    // Unit clause used for the async-reset abort
    cdb_mem[9]  = {{SLW{1'b0}}, {SLW{1'b0}}, slot(1'b1, 6'd12)};
    vs_un_m[12] = 1'b1;

    reset = 1'b1; reset_bcp = 1'b0; bcp_en = 1'b0; bcp_clause_idx = '0; imply_full = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_zero("rst");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Unit clause -> one implication var3 val1
    c0 = n_cdb; p0 = n_push;
    exp_q.push_back({6'd3, 1'b1, 1'b1});
    enq(8'd5);
    wait_idle("unit");
    chk("unit_cdb", 32'(n_cdb - c0), 1);
    chk("unit_push", 32'(n_push - p0), 1);
    chk("unit_conf", 32'(conflict), 0);
    chk("unit_sb", 32'(exp_q.size()), 0);

    // Unit literal in slot 2 with invalid slot 0 and a false literal
    p0 = n_push;
    exp_q.push_back({6'd13, 1'b0, 1'b1});
    enq(8'd11);
    wait_idle("neg");
    chk("neg_push", 32'(n_push - p0), 1);
    chk("neg_sb", 32'(exp_q.size()), 0);

    // Satisfied clause then two-unassigned clause
    c0 = n_cdb; p0 = n_push;
    enq(8'd7);
    enq(8'd8);
    wait_idle("sat");
    chk("sat_cdb", 32'(n_cdb - c0), 2);
    chk("sat_push", 32'(n_push - p0), 0);
    chk("sat_conf", 32'(conflict), 0);

    // Conflict with three more indices queued behind it
    c0 = n_cdb; p0 = n_push;
    enq(8'd2); enq(8'd20); enq(8'd21); enq(8'd22);
    wait_idle("conf");
    chk("conf_flag", 32'(conflict), 1);
    chk("conf_cdb", 32'(n_cdb - c0), 1);
    chk("conf_push", 32'(n_push - p0), 0);
    enq(8'd20);
    repeat (8) @(posedge clock);
    #1;
    chk("conf_ign_cdb", 32'(n_cdb - c0), 1);
    chk("conf_ign_ovf", 32'(q_overflow), 0);
    chk("conf_ign_busy", 32'(bcp_busy), 0);
    // reset_bcp together with bcp_en: conflict cleared, index dropped
    bcp_en = 1'b1; bcp_clause_idx = 8'd20;
    pulse_reset_bcp();
    bcp_en = 1'b0;
    @(negedge clock);
    chk("rbcp_conf", 32'(conflict), 0);
    chk("rbcp_busy", 32'(bcp_busy), 0);
    repeat (8) @(posedge clock);
    #1;
    chk("rbcp_cdb", 32'(n_cdb - c0), 1);
    chk("rbcp_push", 32'(n_push - p0), 0);

    // Empty clause is a conflict
    enq(8'd15);
    wait_idle("empty");
    chk("empty_conf", 32'(conflict), 1);
    pulse_reset_bcp();
    chk("empty_clr", 32'(conflict), 0);

    // Backpressure during PUSH plus queue overflow
    c0 = n_cdb; p0 = n_push;
    imply_full = 1'b1;
    exp_q.push_back({6'd3, 1'b1, 1'b1});
    enq(8'd5);
    repeat (5) @(posedge clock);
    #1;
    for (int i = 0; i < 6; i++) enq(8'(30 + i));
    repeat (4) @(posedge clock);
    #1;
    chk("bp_hold_push", 32'(n_push - p0), 0);
    chk("bp_ovf", 32'(q_overflow), 1);
    imply_full = 1'b0;
    @(negedge clock);
    chk("bp_first", 32'(imply_push), 1);
    @(posedge clock); #1;
    wait_idle("bp");
    chk("bp_cdb", 32'(n_cdb - c0), 5);
    chk("bp_push", 32'(n_push - p0), 1);
    chk("bp_sb", 32'(exp_q.size()), 0);
    chk("bp_ovf_sticky", 32'(q_overflow), 1);
    pulse_reset_bcp();
    chk("bp_ovf_clr", 32'(q_overflow), 0);

    // Asynchronous reset during LREAD aborts the implication
    p0 = n_push;
    enq(8'd9);
    repeat (2) @(posedge clock);
    #1;
    chk("lread_vs", 32'(vs_read), 1);
    reset = 1'b1;
    #1;
    chk_zero("arst");
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("arst_busy", 32'(bcp_busy), 0);
    @(posedge clock); #1;
    exp_q.push_back({6'd3, 1'b1, 1'b1});
    enq(8'd5);
    wait_idle("post");
    chk("post_push", 32'(n_push - p0), 1);
    chk("post_sb", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcp_clause_eval.md
BCP_CLAUSE_EVAL -- requirements
Module: bcp_clause_eval

Interface
REQ-001 Parameter: LITS, 3, literal slots per clause-database word.
REQ-002 Parameter: QDEPTH, 4, depth of the clause-index queue (power of 2).
REQ-003 Port: clock  in  1  single clock; all state updates on posedge.
REQ-004 Port: reset  in  1  asynchronous, active-high; clears all state.
REQ-005 Port: reset_bcp  in  1  synchronous clear of queue, FSM, conflict and overflow.
REQ-006 Port: bcp_en  in  1  clause index valid this cycle.
REQ-007 Port: bcp_clause_idx  in  `MAX_CLAUSES_BITS  clause to evaluate.
REQ-008 Port: bcp_busy  out  1  evaluation pending or in progress.
REQ-009 Port: conflict  out  1  sticky; some clause has every literal false.
REQ-010 Port: q_overflow  out  1  sticky; an index was dropped because the queue was full.
REQ-011 Ports: cdb_read  out  1 and cdb_addr  out  `MAX_CLAUSES_BITS  clause-database read request.
REQ-012 Port: cdb_data  in  LITS*(`MAX_VARS_BITS+2)  slot k = {valid, neg, var}; data is valid 1 cycle after cdb_read.
REQ-013 Ports: vs_read  out  1 and vs_var  out  `MAX_VARS_BITS  var-state read request.
REQ-014 Ports: vs_val  in  1 and vs_unassign  in  1  var-state data, valid 1 cycle after vs_read.
REQ-015 Ports: imply_push  out  1, imply_var  out  `MAX_VARS_BITS, imply_val  out  1, imply_type  out  1, imply_full  in  1  implication-FIFO write port.

Function
REQ-016 Queue: bcp_en with queue not full writes bcp_clause_idx into a FIFO of QDEPTH entries.
REQ-017 Queue full with bcp_en high: index dropped and q_overflow set. A same-cycle pop frees a slot first, so the push is accepted.
REQ-018 FSM states: IDLE, FETCH, LREAD, EVAL, PUSH.
REQ-019 IDLE: if the queue is non-empty and conflict=0, pop the head, drive cdb_read=1 and cdb_addr=head, then go to FETCH.
REQ-020 FETCH: capture cdb_data, then go to LREAD. A clause with no valid slot goes to EVAL as an empty clause.
REQ-021 LREAD: issue one vs_read per valid slot on consecutive cycles in slot order 0..LITS-1, skipping invalid slots. Capture each response in the following cycle.
REQ-022 EVAL is entered the cycle after the last response is captured. Worst-case latency from pop to EVAL is LITS+2 cycles.
REQ-023 Literal evaluation: a literal is true if vs_unassign=0 and vs_val==~neg, false if vs_unassign=0 and vs_val==neg, and unassigned otherwise.
REQ-024 EVAL outcomes:
- any literal true: satisfied, go to IDLE.
- zero unassigned literals (including the empty clause): set conflict, go to IDLE.
- exactly one unassigned literal: go to PUSH.
- two or more unassigned literals: go to IDLE.
REQ-025 PUSH: while imply_full=1, hold with imply_push=0. On the first cycle imply_full=0, assert imply_push for exactly one cycle with imply_var=var, imply_val=~neg, imply_type=1, then go to IDLE.
REQ-026 Duplicate implications are pushed unfiltered. The block never writes var state.
REQ-027 bcp_busy = bcp_en | (queue non-empty) | (state != IDLE), combinational.
REQ-028 When conflict is set, the queue is flushed. Further bcp_en is ignored (no enqueue, no overflow) until reset_bcp.
REQ-029 reset_bcp has priority over bcp_en and any FSM activity in the same cycle. Its effects:
- queue emptied and FSM returned to IDLE.
- conflict and q_overflow cleared.
- an in-flight PUSH is abandoned without imply_push.
- an index presented in the same cycle is dropped.
REQ-030 Queue pointers are log2(QDEPTH) bits wide and wrap modulo QDEPTH, with a separate count of 0..QDEPTH.

Reset
REQ-031 Asynchronous reset drives: state=IDLE, queue empty, and every output 0 (bcp_busy, conflict, q_overflow, cdb_read, cdb_addr, vs_read, vs_var, imply_push, imply_var, imply_val, imply_type).
REQ-032 Reset asserted mid-evaluation aborts the evaluation with no imply_push. After deassertion the block is idle with bcp_busy=0.

Verification
REQ-033 Unit clause: clause 5 = {(1,0,var3), invalid, invalid}, var3 unassigned, one bcp_en -> a single imply_push with var=3, val=1, type=1; conflict=0; bcp_busy low afterwards.
REQ-034 Conflict: clause 2 = {(1,0,v1),(1,1,v2)} with v1=0, v2=1, then 3 more indices queued -> conflict=1, queue flushed, no imply_push, later bcp_en ignored; reset_bcp clears conflict.
REQ-035 Satisfied and multi-unassigned: a clause with one true literal, then a clause with two unassigned literals -> no imply_push, no conflict, 2 cdb_read pulses.
REQ-036 Backpressure and overflow: imply_full=1 held for 10 cycles during PUSH -> imply_push asserted exactly once, on the first cycle after imply_full falls; meanwhile 6 back-to-back bcp_en -> 4 queued, q_overflow=1.
REQ-037 Asynchronous reset asserted during LREAD -> all outputs 0 immediately; a subsequent single-literal unassigned clause gives correct imply_push.
